// File: rtl/shift_cmd_fifo.sv
// rtl/shift_cmd_fifo.sv - command FIFO feeding a 4-bit barrel shifter stage.
// Define SHIFT_FIFO_LEVEL_EN to expose the registered occupancy on port level.
module shift_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_data,
  input  logic [1:0] req_shift,
  input  logic       req_dir,
  input  logic       flush,
  output logic       sh_valid,
  input  logic       sh_ready,
  output logic [3:0] sh_in,
  output logic [1:0] sh_shift,
  output logic       sh_dir
`ifdef SHIFT_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic [6:0]    head;

  // Both handshakes depend only on registered occupancy, so no sh_ready -> req_ready path.
  assign req_ready = (count != FULL);
  assign sh_valid  = (count != '0);
  assign push      = req_valid && req_ready;
  assign pop       = sh_valid && sh_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= {req_data, req_shift, req_dir};
  end

  assign head = mem[rptr];
  assign {sh_in, sh_shift, sh_dir} = sh_valid ? head : 7'd0;

`ifdef SHIFT_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// tb/tb_shift_cmd_fifo.sv - directed self-checking bench for shift_cmd_fifo.
// Level checks are active only when SHIFT_FIFO_LEVEL_EN is defined.
module tb_shift_cmd_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_data;
  logic [1:0] req_shift;
  logic       req_dir;
  logic       flush;
  logic       sh_valid;
  logic       sh_ready;
  logic [3:0] sh_in;
  logic [1:0] sh_shift;
  logic       sh_dir;
`ifdef SHIFT_FIFO_LEVEL_EN
  logic [2:0] level;
`endif

  int vectors = 0;
  int miscompares = 0;

  shift_cmd_fifo #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shift(req_shift), .req_dir(req_dir),
    .flush(flush),
    .sh_valid(sh_valid), .sh_ready(sh_ready),
    .sh_in(sh_in), .sh_shift(sh_shift), .sh_dir(sh_dir)
`ifdef SHIFT_FIFO_LEVEL_EN
    , .level(level)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_level(input string tag, input int exp);
`ifdef SHIFT_FIFO_LEVEL_EN
    check(tag, 32'(level), 32'(exp));
`endif
  endtask

  function automatic logic [6:0] cmd(input logic [3:0] d, input logic [1:0] s, input logic dir);
    return {d, s, dir};
  endfunction

  function automatic logic [6:0] head();
    return {sh_in, sh_shift, sh_dir};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] c, input logic rdy);
    req_valid = v;
    {req_data, req_shift, req_dir} = c;
    sh_ready = rdy;
  endtask

  task automatic push_one(input logic [6:0] c);
    drive(1'b1, c, 1'b0);
    step();
    drive(1'b0, 7'd0, 1'b0);
  endtask

  task automatic pop_expect(input string tag, input logic [6:0] exp);
    check({tag, "_valid"}, 32'(sh_valid), 32'd1);
    check(tag, 32'(head()), 32'(exp));
    drive(1'b0, 7'd0, 1'b1);
    step();
    drive(1'b0, 7'd0, 1'b0);
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_valid"}, 32'(sh_valid), 32'd0);
    check({tag, "_head0"}, 32'(head()), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check_level({tag, "_level"}, 0);
  endtask

  logic [6:0] q [4];
  logic [6:0] c [11];

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, 7'd0, 1'b0);
    #3;
    expect_empty("reset");
    #7 rst = 1'b0;
    step();

    // Single command, held while stalled, no same-cycle bypass.
    drive(1'b1, cmd(4'hD, 2'd0, 1'b0), 1'b0);
    check("nobypass_valid", 32'(sh_valid), 32'd0);
    step();
    drive(1'b0, 7'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 32'(sh_valid), 32'd1);
      check("hold_head", 32'(head()), 32'(cmd(4'hD, 2'd0, 1'b0)));
      check_level("hold_level", 1);
      step();
    end
    pop_expect("single_pop", cmd(4'hD, 2'd0, 1'b0));
    expect_empty("single_empty");

    // Fill to full, fifth command ignored, drain in order.
    q[0] = cmd(4'hD, 2'd1, 1'b0);
    q[1] = cmd(4'hD, 2'd2, 1'b0);
    q[2] = cmd(4'hD, 2'd1, 1'b1);
    q[3] = cmd(4'hD, 2'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 32'(req_ready), 32'd1);
      push_one(q[i]);
    end
    check("full_ready", 32'(req_ready), 32'd0);
    check_level("full_level", 4);
    push_one(cmd(4'h3, 2'd3, 1'b1));
    check("full_ignore_ready", 32'(req_ready), 32'd0);
    check_level("full_ignore_level", 4);
    for (int i = 0; i < 4; i++) pop_expect("drain", q[i]);
    expect_empty("drain_empty");

    // Full with push and pop together: only the pop happens.
    q[0] = cmd(4'h1, 2'd0, 1'b1);
    q[1] = cmd(4'h2, 2'd1, 1'b0);
    q[2] = cmd(4'h4, 2'd2, 1'b1);
    q[3] = cmd(4'h8, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) push_one(q[i]);
    drive(1'b1, cmd(4'hF, 2'd3, 1'b1), 1'b1);
    check("fullpp_ready", 32'(req_ready), 32'd0);
    step();
    drive(1'b0, 7'd0, 1'b0);
    check("fullpp_ready_after", 32'(req_ready), 32'd1);
    check_level("fullpp_level", 3);
    for (int i = 1; i < 4; i++) pop_expect("fullpp_drain", q[i]);
    expect_empty("fullpp_empty");

    // Streaming push+pop every cycle; pointers wrap more than twice.
    for (int i = 0; i < 11; i++) c[i] = {4'(i * 3 + 1), 2'(i), 1'(i)};
    push_one(c[0]);
    for (int i = 1; i < 11; i++) begin
      drive(1'b1, c[i], 1'b1);
      check("stream_valid", 32'(sh_valid), 32'd1);
      check("stream_head", 32'(head()), 32'(c[i-1]));
      check_level("stream_level", 1);
      step();
    end
    drive(1'b0, 7'd0, 1'b0);
    pop_expect("stream_last", c[10]);
    expect_empty("stream_empty");

    // Flush overrides push and pop.
    for (int i = 0; i < 3; i++) push_one(q[i]);
    check_level("preflush_level", 3);
    flush = 1'b1;
    drive(1'b1, cmd(4'h9, 2'd1, 1'b1), 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 7'd0, 1'b0);
    expect_empty("flush");
    step();
    expect_empty("flush_dropped");
    push_one(cmd(4'h6, 2'd2, 1'b0));
    pop_expect("postflush", cmd(4'h6, 2'd2, 1'b0));
    expect_empty("postflush_empty");

    // Asynchronous reset mid-cycle with two entries held.
    push_one(q[0]);
    push_one(q[1]);
    #2 rst = 1'b1;
    #1;
    expect_empty("async_rst");
    #2 rst = 1'b0;
    step();
    push_one(cmd(4'hA, 2'd3, 1'b1));
    check_level("postrst_level", 1);
    pop_expect("postrst", cmd(4'hA, 2'd3, 1'b1));
    expect_empty("postrst_empty");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
